mem_access_sequencer: RTL

Sequences external Flash/SRAM bus cycles for two requesters sharing one memory port. Arbitrates round-robin, decodes the target region from the system address map and drives the active-low CE/OE/WE/WP strobes. Per-region setup/access/hold wait states come from parameters. Sits between the CPU-side request ports and the board-level Flash and SRAM pins.

---
 rtl/mem_map_pkg.sv | 31 +++
 rtl/mem_access_sequencer_if.sv | 51 +++++
 rtl/mem_rr_arbiter.sv | 33 +++
 rtl/mem_access_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map, region/state types and the address decoder shared by the
// memory access sequencer and its testbench.
package mem_map_pkg;

  localparam logic [31:0] FLASH_BASE = 32'h0000_0000;
  localparam logic [31:0] FLASH_LAST = 32'h0FFF_FFFF;
  localparam logic [31:0] SRAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] SRAM_LAST  = 32'h44E1_1FFF;

  typedef enum logic [1:0] {
    REG_FLASH,
    REG_SRAM,
    REG_NONE
  } region_e;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold
  } state_e;

  // Offset-from-base compare: an address below the base wraps to a large
  // offset, so a single unsigned compare covers both bounds.
  function automatic region_e decode_region(input logic [31:0] addr);
    if ((addr - FLASH_BASE) <= (FLASH_LAST - FLASH_BASE)) return REG_FLASH;
    if ((addr - SRAM_BASE) <= (SRAM_LAST - SRAM_BASE)) return REG_SRAM;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request, response and memory-pin bundle for mem_access_sequencer.
// master: requester/board side; slave: the sequencer itself.
interface mem_access_sequencer_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned DW = 16
);
  logic          req0_valid;
  logic          req0_ready;
  logic [N-1:0]  req0_addr;
  logic          req0_we;
  logic [DW-1:0] req0_wdata;

  logic          req1_valid;
  logic          req1_ready;
  logic [N-1:0]  req1_addr;
  logic          req1_we;
  logic [DW-1:0] req1_wdata;

  logic          rsp_valid;
  logic          rsp_id;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;

  logic [N-1:0]  mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wdata_oe;
  logic [DW-1:0] mem_rdata;
  logic          CE;
  logic          OE;
  logic          WE;
  logic          WP;

  modport master (
    output req0_valid, req0_addr, req0_we, req0_wdata,
    output req1_valid, req1_addr, req1_we, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_err, rsp_rdata,
    input  mem_addr, mem_wdata, mem_wdata_oe, CE, OE, WE, WP
  );

  modport slave (
    input  req0_valid, req0_addr, req0_we, req0_wdata,
    input  req1_valid, req1_addr, req1_we, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_err, rsp_rdata,
    output mem_addr, mem_wdata, mem_wdata_oe, CE, OE, WE, WP
  );

endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter. On a tie the requester not served last wins;
// last-served resets to 1 so requester 0 wins the first tie.
module mem_rr_arbiter (
  input  logic       clk,
  input  logic       nRESET,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  logic r_last;

  // Grant decode from pending requests and last-served requester.
  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Remember who was served when a grant is taken.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Flash/SRAM bus-cycle sequencer for two round-robin requesters.
// Optional feature macro: FLASH_WRITE_GUARD_EN (adds flash_wr_unlock; locked
// Flash writes are rejected with rsp_err and no bus cycle).
module mem_access_sequencer
  import mem_map_pkg::*;
#(
  parameter int unsigned N             = 32,
  parameter int unsigned DW            = 16,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned SETUP_CYC     = 1,
  parameter int unsigned FLASH_ACC_CYC = 4,
  parameter int unsigned SRAM_ACC_CYC  = 2,
  parameter int unsigned HOLD_CYC      = 1
) (
  input logic                   clk,
  input logic                   nRESET,
`ifdef FLASH_WRITE_GUARD_EN
  input logic                   flash_wr_unlock,
`endif
  mem_access_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_ACC_CYC - 1);
  localparam logic [CNT_W-1:0] SRAM_LD  = CNT_W'(SRAM_ACC_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_id, r_we;
  region_e           r_region;

  logic              r_ce, r_oe, r_we_n, r_wp, r_wdoe;
  logic              r_rsp_valid, r_rsp_err, r_rsp_id;
  logic [DW-1:0]     r_rsp_rdata;
  logic [N-1:0]      r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;

  logic [1:0]        w_gnt;
  logic              w_idle, w_hs, w_sel, w_sel_we, w_reject, w_hold_done, w_acc_last;
  logic [N-1:0]      w_sel_addr;
  logic [DW-1:0]     w_sel_wdata;
  region_e           w_sel_region;
  logic              w_we_d, w_flash_d, w_busy_d;
  logic              w_ce_d, w_oe_d, w_we_n_d, w_wp_d, w_wdoe_d;
  logic              w_rsp_valid_d, w_rsp_err_d, w_rsp_id_d;

  mem_rr_arbiter u_arb (
    .clk      (clk),
    .nRESET   (nRESET),
    .i_req    ({bus.req1_valid, bus.req0_valid}),
    .i_accept (w_hs),
    .o_gnt    (w_gnt)
  );

  assign w_idle       = (r_state == StIdle);
  assign w_hs         = w_idle & (|w_gnt);
  assign w_sel        = w_gnt[1];
  assign w_sel_addr   = w_sel ? bus.req1_addr : bus.req0_addr;
  assign w_sel_we     = w_sel ? bus.req1_we : bus.req0_we;
  assign w_sel_wdata  = w_sel ? bus.req1_wdata : bus.req0_wdata;
  assign w_sel_region = decode_region(32'(w_sel_addr));
  assign w_hold_done  = (r_state == StHold) & (r_cnt == '0);
  assign w_acc_last   = (r_state == StAccess) & (r_cnt == '0);

`ifdef FLASH_WRITE_GUARD_EN
  assign w_reject = (w_sel_region == REG_NONE) |
                    ((w_sel_region == REG_FLASH) & w_sel_we & ~flash_wr_unlock);
`else
  assign w_reject = (w_sel_region == REG_NONE);
`endif

  assign bus.req0_ready = w_idle & w_gnt[0];
  assign bus.req1_ready = w_idle & w_gnt[1];

  // FSM state register.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next-state logic; rejected requests stay in IDLE.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_hs && !w_reject) w_state_d = StSetup;
      StSetup:  if (r_cnt == '0) w_state_d = StAccess;
      StAccess: if (r_cnt == '0) w_state_d = StHold;
      StHold:   if (r_cnt == '0) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Wait-state counter: load (count-1) on state entry, count down to 0.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_state_d != r_state) begin
      unique case (w_state_d)
        StSetup:  w_cnt_d = SETUP_LD;
        StAccess: w_cnt_d = (r_region == REG_FLASH) ? FLASH_LD : SRAM_LD;
        StHold:   w_cnt_d = HOLD_LD;
        default:  w_cnt_d = '0;
      endcase
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  // Output next-values from the next state; attributes come straight from the
  // granted request on the handshake cycle since the latches are not loaded yet.
  always_comb begin
    w_we_d        = w_hs ? w_sel_we : r_we;
    w_flash_d     = w_hs ? (w_sel_region == REG_FLASH) : (r_region == REG_FLASH);
    w_busy_d      = (w_state_d != StIdle);
    w_ce_d        = ~w_busy_d;
    w_oe_d        = ~((w_state_d == StAccess) & ~w_we_d);
    w_we_n_d      = ~((w_state_d == StAccess) & w_we_d);
    w_wp_d        = w_busy_d & w_we_d & w_flash_d;
    w_wdoe_d      = w_busy_d & w_we_d;
    w_rsp_valid_d = w_hold_done | (w_hs & w_reject);
    w_rsp_err_d   = w_hs & w_reject;
    w_rsp_id_d    = r_rsp_id;
    if (w_hs && w_reject) begin
      w_rsp_id_d = w_sel;
    end else if (w_hold_done) begin
      w_rsp_id_d = r_id;
    end
  end

  // Request latches, registered outputs and read-data capture.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_region    <= REG_NONE;
      r_ce        <= 1'b1;
      r_oe        <= 1'b1;
      r_we_n      <= 1'b1;
      r_wp        <= 1'b0;
      r_wdoe      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_hs) begin
        r_id     <= w_sel;
        r_we     <= w_sel_we;
        r_region <= w_sel_region;
        if (!w_reject) begin
          r_mem_addr  <= w_sel_addr;
          r_mem_wdata <= w_sel_wdata;
        end
      end
      if (w_acc_last && !r_we) begin
        r_rsp_rdata <= bus.mem_rdata;
      end
      r_ce        <= w_ce_d;
      r_oe        <= w_oe_d;
      r_we_n      <= w_we_n_d;
      r_wp        <= w_wp_d;
      r_wdoe      <= w_wdoe_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_err   <= w_rsp_err_d;
      r_rsp_id    <= w_rsp_id_d;
    end
  end

  assign bus.CE           = r_ce;
  assign bus.OE           = r_oe;
  assign bus.WE           = r_we_n;
  assign bus.WP           = r_wp;
  assign bus.mem_wdata_oe = r_wdoe;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_rdata    = r_rsp_rdata;

endmodule
